// File: rtl/spi_adc_pkg.sv
// rtl/spi_adc_pkg.sv - shared types and constants for the SPI ADC scheduler
package spi_adc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        STORE     = 2'd3
    } state_e;

    localparam int ADC_W = 12;
    localparam int ACC_W = 14;

endpackage

// File: rtl/spi_adc_scheduler_rr_pick.sv
// rtl/spi_adc_scheduler_rr_pick.sv - combinational round-robin next-enabled-channel finder
//
// Module rr_pick
//   mask_i : per-channel enable
//   last_i : index of the last serviced channel
//   next_o : first enabled channel after last_i, wrapping at NUM_CH-1
//            (returns last_i when mask_i is all-zero; callers gate on mask_i)
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [CH_W-1:0]   next_o
);

    logic [CH_W-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the closest
    // enabled channel after last_i is the final assignment.
    always_comb begin
        next_o = last_i;
        idx    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_i) + k) % NUM_CH);
            if (mask_i[idx]) begin
                next_o = idx;
            end
        end
    end

endmodule

// File: rtl/spi_adc_scheduler.sv
// rtl/spi_adc_scheduler.sv - periodic round-robin scheduler for an SPI ADC engine
//
// Optional feature macro: SPI_ADC_SCHED_AVG_EN (4-sample per-channel averaging)
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : run scheduler; low lets the current transaction finish
//   period            : cycles between conversion starts (0 behaves as 1)
//   ch_mask           : per-channel enable, sampled at channel selection
//   spi_start/spi_ch  : one-cycle conversion request and its channel
//   spi_done/spi_data : engine completion pulse and 12-bit result
//   sample_*          : captured result, channel and one-cycle valid pulse
//   busy              : transaction in flight (ISSUE..STORE)
//   timeout_err       : sticky watchdog flag, cleared by err_clr
module spi_adc_scheduler
    import spi_adc_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 4095
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic                spi_start,
    output logic [CH_W-1:0]     spi_ch,
    input  logic                spi_done,
    input  logic [ADC_W-1:0]    spi_data,
    output logic [ADC_W-1:0]    sample_data,
    output logic [CH_W-1:0]     sample_ch,
    output logic                sample_valid,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q;
    logic [PERIOD_W-1:0]   per_m1;
    logic                  tick;
    logic                  pick_en;
    logic [CH_W-1:0]       ptr_q;
    logic [CH_W-1:0]       last_idx;
    logic [CH_W-1:0]       pick;
    logic [CH_W-1:0]       ch_q;
    logic [WD_W-1:0]       wd_q;
    logic                  wd_expire;
    logic [ADC_W-1:0]      data_q;
    logic [ADC_W-1:0]      sample_data_q;
    logic [CH_W-1:0]       sample_ch_q;
    logic                  sample_valid_q;
    logic                  err_q;

    assign per_m1  = (period == '0) ? '0 : period - 1'b1;
    assign tick    = enable && (cnt_q >= per_m1);
    assign pick_en = (state_q == IDLE) && tick && (ch_mask != '0);

    // ptr_q is the next channel to consider; rr_pick wants the last one serviced.
    assign last_idx = (ptr_q == '0) ? CH_W'(NUM_CH - 1) : ptr_q - 1'b1;

    // wd_q counts cycles since spi_start, so expiry lands the flag exactly
    // TIMEOUT cycles after the start pulse. A same-cycle spi_done wins.
    assign wd_expire = (state_q == WAIT_DONE) && !spi_done && (wd_q >= WD_W'(TIMEOUT - 1));

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .mask_i (ch_mask),
        .last_i (last_idx),
        .next_o (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_en) state_d = ISSUE;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (spi_done) begin
                    state_d = STORE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            STORE:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

`ifdef SPI_ADC_SCHED_AVG_EN
    logic [ACC_W-1:0] acc_q  [NUM_CH];
    logic [1:0]       cnt4_q [NUM_CH];
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc_q[ch_q] + ACC_W'(data_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q          <= '0;
            ch_q           <= '0;
            wd_q           <= '0;
            data_q         <= '0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
`ifdef SPI_ADC_SCHED_AVG_EN
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                cnt4_q[i] <= '0;
            end
`endif
        end else begin
            sample_valid_q <= 1'b0;

            if (pick_en) begin
                ch_q  <= pick;
                ptr_q <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
            end

            if (state_q == ISSUE) begin
                wd_q <= WD_W'(1);
            end else if (state_q == WAIT_DONE) begin
                wd_q <= wd_q + 1'b1;
            end

            if (state_q == WAIT_DONE && spi_done) begin
                data_q <= spi_data;
            end

            if (wd_expire) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

`ifdef SPI_ADC_SCHED_AVG_EN
            if (wd_expire) begin
                acc_q[ch_q]  <= '0;
                cnt4_q[ch_q] <= '0;
            end
            if (state_q == STORE) begin
                if (cnt4_q[ch_q] == 2'd3) begin
                    sample_data_q  <= acc_sum[ACC_W-1:2];
                    sample_ch_q    <= ch_q;
                    sample_valid_q <= 1'b1;
                    acc_q[ch_q]    <= '0;
                    cnt4_q[ch_q]   <= '0;
                end else begin
                    acc_q[ch_q]  <= acc_sum;
                    cnt4_q[ch_q] <= cnt4_q[ch_q] + 1'b1;
                end
            end
`else
            if (state_q == STORE) begin
                sample_data_q  <= data_q;
                sample_ch_q    <= ch_q;
                sample_valid_q <= 1'b1;
            end
`endif
        end
    end

    assign spi_start    = (state_q == ISSUE);
    assign spi_ch       = ch_q;
    assign busy         = (state_q != IDLE);
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_spi_adc_scheduler.sv
// tb/tb_spi_adc_scheduler.sv - scoreboard bench for spi_adc_scheduler
module tb_spi_adc_scheduler;

    localparam int NUM_CH   = 2;
    localparam int CH_W     = 1;
    localparam int PERIOD_W = 16;
    localparam int TIMEOUT  = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic [NUM_CH-1:0]   ch_mask;
    logic                spi_start;
    logic [CH_W-1:0]     spi_ch;
    logic                spi_done;
    logic [11:0]         spi_data;
    logic [11:0]         sample_data;
    logic [CH_W-1:0]     sample_ch;
    logic                sample_valid;
    logic                busy;
    logic                timeout_err;
    logic                err_clr;

    spi_adc_scheduler #(
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .PERIOD_W (PERIOD_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .ch_mask      (ch_mask),
        .spi_start    (spi_start),
        .spi_ch       (spi_ch),
        .spi_done     (spi_done),
        .spi_data     (spi_data),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          eng_delay = 0;
    logic [11:0] eng_data  = '0;
    int          done_cyc  = -100;
    int          start_count = 0;
    int          sample_count = 0;
    int          last_start_cyc = -1;
    int          chk_period = 0;

    logic [CH_W-1:0]    exp_ch_q  [$];
    logic [CH_W+11:0]   exp_smp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
        end
    endtask

    // Engine model: answers a start after eng_delay cycles; eng_delay=0 never answers.
    initial begin
        spi_done = 1'b0;
        spi_data = '0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1 && eng_delay > 0) begin
                repeat (eng_delay) @(negedge clk);
                spi_data = eng_data;
                spi_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                spi_done = 1'b0;
                spi_data = '0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start or a sample.
    initial begin
        logic [CH_W+11:0] e;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                if (exp_ch_q.size() == 0) begin
                    chk("unexpected_start", 32'(spi_start), 32'd0);
                end else begin
                    chk("start_ch", 32'(spi_ch), 32'(exp_ch_q.pop_front()));
                end
                if (chk_period != 0 && last_start_cyc >= 0) begin
                    chk("start_spacing", cyc - last_start_cyc, chk_period);
                end
                last_start_cyc = cyc;
                start_count++;
            end
            if (sample_valid === 1'b1) begin
                if (exp_smp_q.size() == 0) begin
                    chk("unexpected_sample", 32'(sample_valid), 32'd0);
                end else begin
                    e = exp_smp_q.pop_front();
                    chk("sample_ch", 32'(sample_ch), 32'(e[CH_W+11:12]));
                    chk("sample_data", 32'(sample_data), 32'(e[11:0]));
                end
                chk("sample_latency", cyc - done_cyc, 2);
                sample_count++;
            end
        end
    end

    task automatic wait_starts(input int n, input int budget);
        int b = 0;
        while (start_count < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk("start_count_reached", start_count, n);
    endtask

    task automatic wait_samples(input int budget);
        int b = 0;
        while (exp_smp_q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk("samples_drained", exp_smp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_spi_start"},    32'(spi_start), 0);
        chk({tag, "_spi_ch"},       32'(spi_ch), 0);
        chk({tag, "_sample_data"},  32'(sample_data), 0);
        chk({tag, "_sample_ch"},    32'(sample_ch), 0);
        chk({tag, "_sample_valid"}, 32'(sample_valid), 0);
        chk({tag, "_busy"},         32'(busy), 0);
        chk({tag, "_timeout_err"},  32'(timeout_err), 0);
    endtask

    initial begin
        int s;
        int err_cyc;
        logic busy_hi;

        reset   = 1'b1;
        enable  = 1'b0;
        period  = 16'd10;
        ch_mask = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Basic timing: period 10, both channels, engine answers after 5 cycles.
        eng_delay = 5;
        eng_data  = 12'hABC;
        ch_mask   = 2'b11;
        chk_period = 10;
        last_start_cyc = -1;
        exp_ch_q.push_back(1'b0); exp_ch_q.push_back(1'b1); exp_ch_q.push_back(1'b0);
        exp_smp_q.push_back({1'b0, 12'hABC});
        exp_smp_q.push_back({1'b1, 12'hABC});
        exp_smp_q.push_back({1'b0, 12'hABC});
        @(negedge clk);
        enable = 1'b1;
        wait_starts(3, 100);
        enable = 1'b0;      // dropped mid-transaction: third sample must still appear
        wait_samples(40);
        repeat (30) @(negedge clk);
        chk("disable_idle_busy", 32'(busy), 0);
        chk("disable_no_more_starts", start_count, 3);

        // Masking: only channel 1, then an empty mask.
        eng_data = 12'h123;
        ch_mask  = 2'b10;
        last_start_cyc = -1;
        exp_ch_q.push_back(1'b1); exp_ch_q.push_back(1'b1);
        exp_smp_q.push_back({1'b1, 12'h123});
        exp_smp_q.push_back({1'b1, 12'h123});
        enable = 1'b1;
        wait_starts(5, 100);
        enable = 1'b0;
        wait_samples(40);
        ch_mask = '0;
        enable  = 1'b1;
        busy_hi = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hi = 1'b1;
        end
        chk("mask_zero_busy", 32'(busy_hi), 0);
        chk("mask_zero_starts", start_count, 5);
        enable = 1'b0;

        // Watchdog: channel 0 never answered, channel 1 then served normally.
        eng_delay = 0;
        eng_data  = 12'h456;
        ch_mask   = 2'b11;
        chk_period = 0;
        last_start_cyc = -1;
        exp_ch_q.push_back(1'b0); exp_ch_q.push_back(1'b1);
        exp_smp_q.push_back({1'b1, 12'h456});
        @(negedge clk);
        enable = 1'b1;
        wait_starts(6, 40);
        s = last_start_cyc;
        err_cyc = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1 && err_cyc < 0) begin
                err_cyc   = cyc;
                eng_delay = 5;
            end
        end
        chk("timeout_latency", err_cyc - s, 20);
        chk("timeout_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_clears", 32'(timeout_err), 0);
        wait_starts(7, 40);
        enable = 1'b0;
        wait_samples(40);

        // Slow engine with period 1: back-to-back, one idle cycle between.
        eng_delay = 15;
        eng_data  = 12'h7E5;
        period    = 16'd1;
        chk_period = 18;
        last_start_cyc = -1;
        exp_ch_q.push_back(1'b0); exp_ch_q.push_back(1'b1); exp_ch_q.push_back(1'b0);
        exp_smp_q.push_back({1'b0, 12'h7E5});
        exp_smp_q.push_back({1'b1, 12'h7E5});
        exp_smp_q.push_back({1'b0, 12'h7E5});
        enable = 1'b1;
        wait_starts(10, 120);
        enable = 1'b0;
        wait_samples(60);

        // Reset during WAIT_DONE; the late spi_done must be ignored.
        eng_delay = 10;
        eng_data  = 12'h3C3;
        chk_period = 0;
        exp_ch_q.push_back(1'b1);
        enable = 1'b1;
        wait_starts(11, 20);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("late_done_busy", 32'(busy), 0);
        chk("late_done_no_sample", sample_count, 9);

        // After reset the pointer restarts at channel 0.
        eng_delay = 3;
        eng_data  = 12'h0F0;
        last_start_cyc = -1;
        exp_ch_q.push_back(1'b0);
        exp_smp_q.push_back({1'b0, 12'h0F0});
        enable = 1'b1;
        wait_starts(12, 20);
        enable = 1'b0;
        wait_samples(20);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
